arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width of the data stream.
REQ-002 Parameter LEN_WIDTH, default 8: width of cmd_len; burst length is cmd_len+1 beats (1..2^LEN_WIDTH).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  burst command offered.
REQ-007 cmd_len  in  LEN_WIDTH  beats minus one.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 request  out  1  this port's request bit to the round-robin blocking arbiter.
REQ-010 grant  in  1  this port's grant bit from the arbiter.
REQ-011 acknowledge  out  1  one-cycle release pulse to the arbiter.
REQ-012 s_valid / s_ready / s_data  in / out / DATA_WIDTH  source data stream.
REQ-013 out_valid / out_ready / out_data / out_last  out / in / DATA_WIDTH / out  shared-bus data stream.
REQ-014 grant_lost_err  out  1  sticky error flag.

Function
REQ-015 FSM states IDLE, REQ, XFER, ACK; reset state IDLE.
REQ-016 cmd_ready is high only in IDLE with rst_n high; all other states low.
REQ-017 IDLE: on cmd_valid&cmd_ready, latch cmd_len into beat counter, go REQ; request high from the next cycle.
REQ-018 REQ: request high; on grant=1 go XFER next cycle; unbounded wait, no timeout.
REQ-019 XFER: request held high; out_valid = s_valid & grant; s_ready = out_ready & grant; out_data = s_data combinationally.
REQ-020 A beat transfers when out_valid&out_ready; the counter decrements by 1 per beat; out_last = out_valid & (counter==0).
REQ-021 Transfer of the beat with counter==0 moves to ACK next cycle.
REQ-022 ACK: acknowledge=1 and request=0 for exactly one cycle, then IDLE; cmd_ready returns high the cycle after ACK.
REQ-023 Minimum spacing: a new command accepted in the first IDLE cycle raises request again one cycle later (request low at least 2 cycles between bursts).
REQ-024 Grant deasserted in XFER: out_valid and s_ready forced low, counter frozen, state stays XFER, request held; grant_lost_err set to 1 and held until reset.
REQ-025 Grant returning in XFER resumes the burst at the frozen count; no beat duplicated or dropped.
REQ-026 Grant high in IDLE or ACK is ignored; acknowledge never asserted outside ACK.
REQ-027 cmd_valid while not IDLE is not accepted and leaves state unaffected.
REQ-028 Outside XFER: out_valid=0, s_ready=0, out_last=0.
REQ-029 Counter is LEN_WIDTH bits, never wraps: XFER exits at counter 0, so underflow is unreachable.

Reset
REQ-030 rst_n low asynchronously forces IDLE, counter 0, request 0, acknowledge 0, out_valid 0, s_ready 0, out_last 0, cmd_ready 0, grant_lost_err 0.
REQ-031 Reset mid-burst abandons the burst without an acknowledge pulse; first cycle after release is IDLE with cmd_ready 1.
REQ-032 Release of rst_n is synchronized internally (two-flop) so state leaves reset on a clk edge.

Verification
REQ-033 cmd_len=0, grant 2 cycles after request, out_ready=1, s_valid=1 -> one beat with out_last=1, acknowledge pulse the next cycle, request low in that cycle.
REQ-034 cmd_len=3, out_ready toggling 1,0,1,0... -> exactly 4 beats, data order preserved, out_last only on 4th, one acknowledge.
REQ-035 cmd_len=7, grant dropped 3 cycles after beat 2 then restored -> no beats while low, grant_lost_err=1 sticky, beats 3..8 delivered, one acknowledge.
REQ-036 cmd_valid held high for back-to-back len=1 commands -> request low for 2 cycles between bursts, each burst 2 beats, one acknowledge each.
REQ-037 rst_n pulsed low during beat 5 of a len=15 burst -> all outputs zero immediately, no acknowledge, cmd_ready=1 after release, next command completes normally.
REQ-038 cmd_len=255 (max) with two instances on a 4-port round-robin blocking arbiter with acknowledge release -> each gets 256 uninterleaved beats, grants alternate.

Source files
------------

// File: rtl/arb_requester.sv
// Burst requester: wins a grant from a round-robin blocking arbiter, streams one
// burst of cmd_len+1 beats onto the shared bus, then releases with an acknowledge pulse.
module arb_requester #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  cmd_ready,
   output logic                  request,
   input  logic                  grant,
   output logic                  acknowledge,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  grant_lost_err
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, ACK} state_t;

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] count, count_nxt;
   logic                 lost, lost_nxt;
   logic [1:0]           rst_sync_q;
   logic                 rst_sync;
   logic                 in_xfer;
   logic                 beat;

   // NOTE: assertion of reset is immediate, but its release passes through two
   // flops so the FSM always leaves reset on a clean clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_sync = rst_sync_q[1];

   // NOTE: state registers use non-blocking assignments only; all decisions live
   // in the combinational block below.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         state <= IDLE;
         count <= '0;
         lost  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         lost  <= lost_nxt;
      end
   end

   assign in_xfer = (state == XFER);
   assign beat    = out_valid & out_ready;

   // NOTE: every variable gets its hold value first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      lost_nxt  = lost | (in_xfer & ~grant);
      unique case (state)
         IDLE: if (cmd_valid && cmd_ready) begin
            state_nxt = REQ;
            count_nxt = cmd_len;
         end
         REQ:  if (grant) state_nxt = XFER;
         XFER: if (beat) begin
            // The beat at count 0 is the last one, so the counter never underflows.
            if (count == '0) state_nxt = ACK;
            else             count_nxt = count - 1'b1;
         end
         ACK:  state_nxt = IDLE;
      endcase
   end

   assign cmd_ready      = (state == IDLE) & rst_sync;
   assign request        = (state == REQ) | in_xfer;
   assign acknowledge    = (state == ACK);
   assign out_valid      = in_xfer & grant & s_valid;
   assign s_ready        = in_xfer & grant & out_ready;
   assign out_data       = s_data;
   assign out_last       = out_valid & (count == '0);
   assign grant_lost_err = lost;

endmodule

// File: tb/tb_arb_requester.sv
// Randomized directed bench for arb_requester: the bench plays arbiter, source and
// sink, and predicts each cycle from burst-level bookkeeping (beats done, grant history).
module tb_arb_requester;
   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [LW-1:0] cmd_len = '0;
   logic          grant = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          out_ready = 1'b0;
   logic          cmd_ready, request, acknowledge, s_ready, out_valid, out_last, grant_lost_err;
   logic [DW-1:0] out_data;

   int passed = 0;
   int total  = 0;
   bit lost_exp = 1'b0;

   always #5 clk = ~clk;

   arb_requester #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
      .request(request), .grant(grant), .acknowledge(acknowledge),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .grant_lost_err(grant_lost_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_request"}, request, 0);
      chk({tag, "_ack"}, acknowledge, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_lost_err"}, grant_lost_err, 0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6 && !cmd_ready; i++) begin
         @(posedge clk); #1;
         chk("post_reset_ack", acknowledge, 0);
         chk("post_reset_request", request, 0);
      end
      chk("post_reset_cmd_ready", cmd_ready, 1);
   endtask

   // mode: 0 random source/sink, 1 always valid/ready, 2 source valid with out_ready toggling.
   // drop_beat >= 0: three cycles after that many beats, grant is withdrawn for drop_len cycles.
   // rst_beat >= 0: reset is pulsed while that many beats have completed.
   task automatic do_burst(input int len, input int gdelay, input int mode, input int drop_beat,
                           input int drop_len, input bit keep_valid, input int rst_beat);
      int            beats = 0;
      int            cyc = 0;
      int            dcnt = 0;
      bit            in_xfer = 0;
      bit            ack_due = 0;
      bit            done = 0;
      bit            tog = 1;
      bit            ov, sr;
      logic [DW-1:0] word = $urandom;

      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      grant     = 1'($urandom_range(0, 1));
      s_valid   = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_request", request, 0);
      chk("idle_ack", acknowledge, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_s_ready", s_ready, 0);

      while (!done && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         cmd_valid = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
         cmd_len   = LW'($urandom);
         if (ack_due) begin
            grant     = 1'($urandom_range(0, 1));
            s_valid   = 1'b1;
            out_ready = 1'b1;
            #1;
            chk("ack_pulse", acknowledge, 1);
            chk("ack_request_low", request, 0);
            chk("ack_out_valid", out_valid, 0);
            chk("ack_s_ready", s_ready, 0);
            chk("ack_out_last", out_last, 0);
            chk("ack_cmd_ready", cmd_ready, 0);
            chk("ack_lost_err", grant_lost_err, lost_exp);
            done = 1;
         end else begin
            if (in_xfer) begin
               if (drop_beat >= 0 && beats >= drop_beat) dcnt++;
               grant = !(dcnt > 3 && dcnt <= 3 + drop_len);
            end else begin
               grant = (cyc >= 1 + gdelay);
            end
            case (mode)
               1: begin s_valid = 1'b1; out_ready = 1'b1; end
               2: begin s_valid = 1'b1; out_ready = tog; tog = ~tog; end
               default: begin
                  s_valid   = ($urandom_range(0, 3) != 0);
                  out_ready = ($urandom_range(0, 3) != 0);
               end
            endcase
            s_data = word;
            #1;
            if (rst_beat >= 0 && in_xfer && beats == rst_beat) begin
               rst_n = 1'b0;
               #1;
               chk_all_zero("mid_reset");
               lost_exp  = 1'b0;
               cmd_valid = 1'b0;
               grant     = 1'b0;
               s_valid   = 1'b0;
               out_ready = 1'b0;
               release_reset();
               return;
            end
            ov = in_xfer & grant & s_valid;
            sr = in_xfer & grant & out_ready;
            chk("burst_request", request, 1);
            chk("burst_ack", acknowledge, 0);
            chk("burst_cmd_ready", cmd_ready, 0);
            chk("burst_out_valid", out_valid, ov);
            chk("burst_s_ready", s_ready, sr);
            chk("burst_out_last", out_last, ov & (beats == len));
            chk("burst_lost_err", grant_lost_err, lost_exp);
            if (ov) chk("burst_data", out_data, word);
            if (ov && out_ready) begin
               beats++;
               word = $urandom;
               if (beats == len + 1) ack_due = 1;
            end
            if (in_xfer && !grant) lost_exp = 1'b1;
            if (!in_xfer && grant) in_xfer = 1;
         end
      end
      if (!done) chk("burst_timeout", 0, 1);
      chk("burst_beat_count", beats, len + 1);
      if (!keep_valid) cmd_valid = 1'b0;
   endtask

   initial begin
      #2;
      chk_all_zero("reset");
      release_reset();

      // Single beat, grant two cycles after request.
      do_burst(0, 2, 1, -1, 0, 0, -1);
      // Four beats against a toggling sink.
      do_burst(3, 1, 2, -1, 0, 0, -1);
      // Grant withdrawn mid-burst, then restored.
      do_burst(7, 0, 1, 2, 4, 0, -1);
      chk("lost_err_sticky", grant_lost_err, 1);
      // Back-to-back two-beat bursts with cmd_valid held high.
      do_burst(1, 0, 1, -1, 0, 1, -1);
      do_burst(1, 0, 1, -1, 0, 1, -1);
      do_burst(1, 1, 1, -1, 0, 0, -1);
      // Reset during the fifth beat of a sixteen-beat burst, then a normal burst.
      do_burst(15, 0, 1, -1, 0, 0, 4);
      chk("reset_clears_lost_err", grant_lost_err, 0);
      do_burst(2, 1, 0, -1, 0, 0, -1);
      // Maximum-length burst.
      do_burst(255, 3, 0, -1, 0, 0, -1);
      // Random mix.
      for (int i = 0; i < 8; i++)
         do_burst($urandom_range(0, 20), $urandom_range(0, 4), 0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1,
                  $urandom_range(1, 5), 0, -1);

      @(posedge clk); #1;
      chk("final_idle_cmd_ready", cmd_ready, 1);
      chk("final_idle_request", request, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
